// File: rtl/axi4_lite_write_slave_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_slave_if
//
// AXI4-Lite write-channel bundle (AW, W and B channels) shared between a
// write master and the write slave.
//
// Parameters:
//   ADDR_WIDTH  width of S_AXI_AWADDR
//   DATA_WIDTH  width of S_AXI_WDATA; S_AXI_WSTRB is DATA_WIDTH/8 bits
//
// Signals:
//   S_AXI_AWADDR/AWVALID/AWREADY  write address channel
//   S_AXI_WDATA/WSTRB/WVALID/WREADY  write data channel
//   S_AXI_BRESP/BVALID/BREADY  write response channel
//
// Modports:
//   master  drives address, data and BREADY; observes readies and response
//   slave   the mirror image of master
// ---------------------------------------------------------------------------
interface axi4_lite_write_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );
endinterface

// File: rtl/axi4_lite_write_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_slave
//
// AXI4-Lite write responder. Collects one AW beat and one W beat in either
// order, performs a single write on a simple local port, then returns a B
// response. Addresses outside [BASE_ADDR, BASE_ADDR+ADDR_RANGE) never reach
// the local port and are answered with SLVERR. One transaction at a time.
//
// Parameters:
//   ADDR_WIDTH  AXI and local address width
//   DATA_WIDTH  data width; strobe width is DATA_WIDTH/8
//   BASE_ADDR   first byte address decoded by this slave
//   ADDR_RANGE  size of the decoded window in bytes
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   s_axi      AXI4-Lite write channels (slave modport)
//   mem_we     local write request, held until mem_ready
//   mem_addr   byte offset from BASE_ADDR
//   mem_wdata  buffered write data
//   mem_wstrb  buffered byte enables
//   mem_ready  local side completes the write this cycle
// ---------------------------------------------------------------------------
module axi4_lite_write_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           ADDR_RANGE = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    axi4_lite_write_slave_if.slave  s_axi,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // One extra bit so the window size can be compared against a full-width
    // offset without wrapping when ADDR_RANGE reaches 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] RANGE_EXT = (ADDR_WIDTH + 1)'(ADDR_RANGE);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP
    } state_t;

    state_t                  state;
    logic                    aw_full;
    logic                    w_full;
    logic [ADDR_WIDTH-1:0]   addr_buf;
    logic [DATA_WIDTH-1:0]   data_buf;
    logic [STRB_WIDTH-1:0]   strb_buf;
    logic                    in_range_buf;
    logic                    awready_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [STRB_WIDTH-1:0]   strb_next;
    logic [ADDR_WIDTH-1:0]   offset_next;
    logic                    in_range_next;

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;

    // Buffer contents as they will look after this edge. A beat accepted
    // this cycle is forwarded straight into the local-port registers so a
    // simultaneous AW+W reaches the local port one cycle later. The offset
    // is a plain modulo subtraction; unaligned addresses are not altered.
    always_comb begin
        aw_hs         = (state == IDLE) && s_axi.S_AXI_AWVALID && awready_q;
        w_hs          = (state == IDLE) && s_axi.S_AXI_WVALID && wready_q;
        addr_next     = aw_hs ? s_axi.S_AXI_AWADDR : addr_buf;
        data_next     = w_hs ? s_axi.S_AXI_WDATA : data_buf;
        strb_next     = w_hs ? s_axi.S_AXI_WSTRB : strb_buf;
        offset_next   = addr_next - BASE_ADDR;
        in_range_next = in_range_buf;
        if (aw_hs) begin
            in_range_next = (s_axi.S_AXI_AWADDR >= BASE_ADDR) &&
                            ({1'b0, offset_next} < RANGE_EXT);
        end
    end

    // Transaction sequencer. IDLE collects the two beats, each channel
    // back-pressuring independently once its buffer is full. WRITE either
    // holds the local request until mem_ready or, for a decode miss, skips
    // the local port entirely. RESP holds BVALID/BRESP until BREADY, then
    // frees both buffers and reopens the readies on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            addr_buf     <= '0;
            data_buf     <= '0;
            strb_buf     <= '0;
            in_range_buf <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        addr_buf     <= addr_next;
                        in_range_buf <= in_range_next;
                        aw_full      <= 1'b1;
                    end
                    if (w_hs) begin
                        data_buf <= data_next;
                        strb_buf <= strb_next;
                        w_full   <= 1'b1;
                    end
                    if ((aw_full || aw_hs) && (w_full || w_hs)) begin
                        state     <= WRITE;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (in_range_next) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= offset_next;
                            mem_wdata <= data_next;
                            mem_wstrb <= strb_next;
                        end
                    end else begin
                        awready_q <= !(aw_full || aw_hs);
                        wready_q  <= !(w_full || w_hs);
                    end
                end

                WRITE: begin
                    if (!in_range_buf) begin
                        state    <= RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= 2'b10;
                    end else if (mem_ready) begin
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= 2'b00;
                    end
                end

                RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        aw_full   <= 1'b0;
                        w_full    <= 1'b0;
                        state     <= IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_write_slave
//
// Directed bench for axi4_lite_write_slave. One instance uses the default
// decode window (base 0, 4 KiB); a second uses base 0x1000, range 0x100 for
// the decode-boundary scenarios. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_axi4_lite_write_slave;

    logic        clk;
    logic        rst;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;

    logic        mem2_we;
    logic [31:0] mem2_addr;
    logic [31:0] mem2_wdata;
    logic [3:0]  mem2_wstrb;
    logic        mem2_ready;

    int checks;
    int errors;
    int mem_write_count;

    axi4_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
    axi4_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi2 ();

    axi4_lite_write_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (32'h0000_0000),
        .ADDR_RANGE(4096)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi    (axi),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready)
    );

    axi4_lite_write_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (32'h0000_1000),
        .ADDR_RANGE(256)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .s_axi    (axi2),
        .mem_we   (mem2_we),
        .mem_addr (mem2_addr),
        .mem_wdata(mem2_wdata),
        .mem_wstrb(mem2_wstrb),
        .mem_ready(mem2_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts completed local writes on the default-window instance so the
    // scenarios can detect lost or duplicated writes.
    always @(posedge clk) begin
        if (mem_we && mem_ready) mem_write_count <= mem_write_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        axi.S_AXI_AWADDR   = '0;
        axi.S_AXI_AWVALID  = 1'b0;
        axi.S_AXI_WDATA    = '0;
        axi.S_AXI_WSTRB    = '0;
        axi.S_AXI_WVALID   = 1'b0;
        axi.S_AXI_BREADY   = 1'b0;
        mem_ready          = 1'b0;
        axi2.S_AXI_AWADDR  = '0;
        axi2.S_AXI_AWVALID = 1'b0;
        axi2.S_AXI_WDATA   = '0;
        axi2.S_AXI_WSTRB   = '0;
        axi2.S_AXI_WVALID  = 1'b0;
        axi2.S_AXI_BREADY  = 1'b0;
        mem2_ready         = 1'b0;
    endtask

    // Outputs held low during reset, readies open after release.
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, mem_we} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 0000",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, mem_we});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BRESP, mem_addr} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_held got %h expected 0",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BRESP, mem_addr});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi2.S_AXI_AWREADY, axi2.S_AXI_WREADY} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_release_readies got %b expected 1111",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi2.S_AXI_AWREADY, axi2.S_AXI_WREADY});
        end
    endtask

    // AW and W in the same cycle, no stalls.
    task automatic test_simultaneous();
        axi.S_AXI_AWADDR  = 32'h10;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'hDEAD_BEEF;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        mem_ready         = 1'b1;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("[TB] FAIL simul_mem got we=%b addr=%h data=%h strb=%h expected 1/10/deadbeef/f",
                     mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL simul_write_flags got %b expected 000",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID});
        end
        tick();
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, mem_we, mem_addr} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL simul_resp got bvalid=%b bresp=%b we=%b addr=%h expected 1/00/0/0",
                     axi.S_AXI_BVALID, axi.S_AXI_BRESP, mem_we, mem_addr);
        end
        axi.S_AXI_BREADY = 1'b1;
        tick();
        axi.S_AXI_BREADY = 1'b0;
        mem_ready        = 1'b0;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL simul_after_b got %b expected 011",
                     {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
        end
    endtask

    // W beat first, AW three cycles later; W stays back-pressured.
    task automatic test_w_first();
        int start_count;
        start_count      = mem_write_count;
        mem_ready        = 1'b1;
        axi.S_AXI_WDATA  = 32'hCAFE_F00D;
        axi.S_AXI_WSTRB  = 4'h3;
        axi.S_AXI_WVALID = 1'b1;
        tick();
        axi.S_AXI_WDATA  = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({axi.S_AXI_WREADY, axi.S_AXI_AWREADY, mem_we} !== 3'b010) begin
                errors++;
                $display("[TB] FAIL wfirst_wait%0d got wready/awready/we=%b expected 010",
                         i, {axi.S_AXI_WREADY, axi.S_AXI_AWREADY, mem_we});
            end
            if (i == 2) begin
                axi.S_AXI_WVALID  = 1'b0;
                axi.S_AXI_AWADDR  = 32'h24;
                axi.S_AXI_AWVALID = 1'b1;
            end
            tick();
        end
        axi.S_AXI_AWVALID = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h24, 32'hCAFE_F00D, 4'h3}) begin
            errors++;
            $display("[TB] FAIL wfirst_mem got we=%b addr=%h data=%h strb=%h expected 1/24/cafef00d/3",
                     mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        tick();
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_WREADY} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL wfirst_resp got bvalid/bresp/wready=%b expected 1000",
                     {axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_WREADY});
        end
        axi.S_AXI_BREADY = 1'b1;
        tick();
        axi.S_AXI_BREADY = 1'b0;
        mem_ready        = 1'b0;
        checks++;
        if (mem_write_count - start_count !== 1) begin
            errors++;
            $display("[TB] FAIL wfirst_write_count got %0d expected 1", mem_write_count - start_count);
        end
    endtask

    // Local port stalls 4 cycles, then the master stalls B for 3 cycles.
    task automatic test_stall();
        axi.S_AXI_AWADDR  = 32'h40;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h1234_5678;
        axi.S_AXI_WSTRB   = 4'hC;
        axi.S_AXI_WVALID  = 1'b1;
        mem_ready         = 1'b0;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_WDATA   = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, mem_wstrb, axi.S_AXI_BVALID} !==
                {1'b1, 32'h40, 32'h1234_5678, 4'hC, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_mem%0d got we=%b addr=%h data=%h strb=%h bvalid=%b expected 1/40/12345678/c/0",
                         i, mem_we, mem_addr, mem_wdata, mem_wstrb, axi.S_AXI_BVALID);
            end
            if (i == 4) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP, mem_we, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 6'b100000) begin
                errors++;
                $display("[TB] FAIL stall_bhold%0d got bvalid/bresp/we/awr/wr=%b expected 100000",
                         i, {axi.S_AXI_BVALID, axi.S_AXI_BRESP, mem_we, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
            end
            tick();
        end
        axi.S_AXI_BREADY = 1'b1;
        tick();
        axi.S_AXI_BREADY = 1'b0;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL stall_release got %b expected 011",
                     {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
        end
    endtask

    // Decode window 0x1000..0x10FF on the second instance.
    task automatic test_out_of_range();
        logic [31:0] addrs [4];
        logic        hits  [4];
        logic [31:0] offs  [4];
        addrs[0] = 32'h1100; hits[0] = 1'b0; offs[0] = 32'h0;
        addrs[1] = 32'h10FC; hits[1] = 1'b1; offs[1] = 32'hFC;
        addrs[2] = 32'h0FFF; hits[2] = 1'b0; offs[2] = 32'h0;
        addrs[3] = 32'h1000; hits[3] = 1'b1; offs[3] = 32'h0;
        mem2_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi2.S_AXI_AWADDR  = addrs[i];
            axi2.S_AXI_AWVALID = 1'b1;
            axi2.S_AXI_WDATA   = 32'hA5A5_0000 + i;
            axi2.S_AXI_WSTRB   = 4'hF;
            axi2.S_AXI_WVALID  = 1'b1;
            tick();
            axi2.S_AXI_AWVALID = 1'b0;
            axi2.S_AXI_WVALID  = 1'b0;
            checks++;
            if (mem2_we !== hits[i] || (hits[i] && mem2_addr !== offs[i])) begin
                errors++;
                $display("[TB] FAIL range_mem%0d got we=%b addr=%h expected we=%b addr=%h",
                         i, mem2_we, mem2_addr, hits[i], offs[i]);
            end
            tick();
            checks++;
            if ({axi2.S_AXI_BVALID, axi2.S_AXI_BRESP, mem2_we} !== {1'b1, (hits[i] ? 2'b00 : 2'b10), 1'b0}) begin
                errors++;
                $display("[TB] FAIL range_resp%0d got bvalid/bresp/we=%b expected %b",
                         i, {axi2.S_AXI_BVALID, axi2.S_AXI_BRESP, mem2_we},
                         {1'b1, (hits[i] ? 2'b00 : 2'b10), 1'b0});
            end
            axi2.S_AXI_BREADY = 1'b1;
            tick();
            axi2.S_AXI_BREADY = 1'b0;
        end
        mem2_ready = 1'b0;
    endtask

    // Reset during a stalled local write abandons it; the next one works.
    task automatic test_reset_mid();
        axi.S_AXI_AWADDR  = 32'h80;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h5555_AAAA;
        axi.S_AXI_WSTRB   = 4'hF;
        axi.S_AXI_WVALID  = 1'b1;
        mem_ready         = 1'b0;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_pre_we got %b expected 1", mem_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_addr, axi.S_AXI_BVALID} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_async got we/addr/bvalid=%h expected 0",
                     {mem_we, mem_addr, axi.S_AXI_BVALID});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, mem_we} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL rstmid_idle got %b expected 1100",
                     {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, mem_we});
        end
        axi.S_AXI_AWADDR  = 32'h84;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = 32'h0BAD_F00D;
        axi.S_AXI_WSTRB   = 4'h6;
        axi.S_AXI_WVALID  = 1'b1;
        mem_ready         = 1'b1;
        tick();
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h84, 32'h0BAD_F00D, 4'h6}) begin
            errors++;
            $display("[TB] FAIL rstmid_next_mem got we=%b addr=%h data=%h strb=%h expected 1/84/0badf00d/6",
                     mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        axi.S_AXI_BREADY = 1'b1;
        tick();
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL rstmid_next_resp got %b expected 100",
                     {axi.S_AXI_BVALID, axi.S_AXI_BRESP});
        end
        tick();
        axi.S_AXI_BREADY = 1'b0;
        mem_ready        = 1'b0;
    endtask

    // Three stores from a master that holds AW and W together, including a
    // zero strobe, with BREADY and mem_ready held high.
    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic [3:0]  strbs [3];
        int          start_count;
        int          waited;
        addrs[0] = 32'h100; datas[0] = 32'h0000_0001; strbs[0] = 4'h1;
        addrs[1] = 32'h204; datas[1] = 32'h0000_0002; strbs[1] = 4'h0;
        addrs[2] = 32'h30A; datas[2] = 32'h0000_0003; strbs[2] = 4'h8;
        start_count      = mem_write_count;
        axi.S_AXI_BREADY = 1'b1;
        mem_ready        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            axi.S_AXI_AWADDR  = addrs[i];
            axi.S_AXI_WDATA   = datas[i];
            axi.S_AXI_WSTRB   = strbs[i];
            axi.S_AXI_AWVALID = 1'b1;
            axi.S_AXI_WVALID  = 1'b1;
            waited = 0;
            while (!(axi.S_AXI_AWREADY && axi.S_AXI_WREADY) && waited < 20) begin
                tick();
                waited++;
            end
            checks++;
            if (!(axi.S_AXI_AWREADY && axi.S_AXI_WREADY)) begin
                errors++;
                $display("[TB] FAIL b2b_ready%0d got awr/wr=%b%b expected 11 within 20 cycles",
                         i, axi.S_AXI_AWREADY, axi.S_AXI_WREADY);
            end
            tick();
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
            checks++;
            if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, addrs[i], datas[i], strbs[i]}) begin
                errors++;
                $display("[TB] FAIL b2b_mem%0d got we=%b addr=%h data=%h strb=%h expected 1/%h/%h/%h",
                         i, mem_we, mem_addr, mem_wdata, mem_wstrb, addrs[i], datas[i], strbs[i]);
            end
            tick();
            checks++;
            if ({axi.S_AXI_BVALID, axi.S_AXI_BRESP} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL b2b_resp%0d got %b expected 100", i, {axi.S_AXI_BVALID, axi.S_AXI_BRESP});
            end
            tick();
        end
        axi.S_AXI_BREADY = 1'b0;
        mem_ready        = 1'b0;
        checks++;
        if (mem_write_count - start_count !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_write_count got %0d expected 3", mem_write_count - start_count);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        mem_write_count = 0;
        test_reset();
        test_simultaneous();
        test_w_first();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
